// File: rtl/io_mmio_ctrl.sv
// -----------------------------------------------------------------------------
// io_mmio_ctrl
//
// Memory-mapped I/O controller on the CPU data bus. It takes over from the old
// single-address debug print port and claims a 4-word window at BASE:
//
//   offset 0  TXDATA  (W)    push data[7:0] into the TX byte FIFO, reads 0
//   offset 1  STATUS  (R/W1C)
//                     [0] tx_full  [1] tx_empty  [2] rx_valid
//                     [3] tx_ovf (sticky, W1C)   [4] rx_ovr (sticky, W1C)
//                     [15:8] tx_count
//   offset 2  RXDATA  (R)    {0, rx_hold}, the read clears rx_valid
//   offset 3  CYCLES  (R)    free-running cycle counter, writes ignored
//
// Ports
//   clk        system clock, all state on posedge
//   rst        asynchronous active-high reset
//   addr       bus address (ADDR_W)
//   data       bus write data (DATA_W)
//   write      write strobe
//   read       read strobe
//   data_out   registered read data, 1-cycle latency, 0 after no read / miss
//   tx_data    TX FIFO head byte (combinational)
//   tx_valid   TX FIFO non-empty (combinational)
//   tx_ready   sink accepts head when tx_valid & tx_ready
//   rx_byte    incoming byte
//   rx_strobe  one-cycle pulse capturing rx_byte
//
// Optional feature
//   IO_SIM_PRINT_EN  when defined, every accepted TX pop echoes the byte to the
//                    simulator console with $write. Simulation only.
// -----------------------------------------------------------------------------
module io_mmio_ctrl #(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] BASE     = 16'h0000,
    parameter int                TX_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    input  logic              write,
    input  logic              read,
    output logic [DATA_W-1:0] data_out,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [7:0]        rx_byte,
    input  logic              rx_strobe
);

    localparam int PTR_W = $clog2(TX_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(TX_DEPTH);
    localparam logic [PTR_W-1:0]  PTR_ZERO = PTR_W'(0);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [DATA_W-1:0] DATA_ZERO = DATA_W'(0);
    localparam logic [DATA_W-1:0] DATA_ONE  = DATA_W'(1);

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_RXDATA = 2'd2;
    localparam logic [1:0] OFF_CYCLES = 2'd3;

    // ------------------------------------------------------------------ state
    logic [7:0]        tx_mem_r [TX_DEPTH];
    logic [PTR_W-1:0]  tx_wr_ptr_r;
    logic [PTR_W-1:0]  tx_rd_ptr_r;
    logic [CNT_W-1:0]  tx_count_r;
    logic              tx_ovf_r;
    logic [7:0]        rx_hold_r;
    logic              rx_valid_r;
    logic              rx_ovr_r;
    logic [DATA_W-1:0] cycles_r;

    // ----------------------------------------------------------------- decode
    logic              hit_s;
    logic [1:0]        off_s;
    logic              wr_hit_s;
    logic              rd_hit_s;
    logic              tx_full_s;
    logic              tx_empty_s;
    logic              push_req_s;
    logic              push_s;
    logic              push_drop_s;
    logic              pop_s;
    logic              rd_rx_s;
    logic              stat_wr_s;
    logic              clr_ovf_s;
    logic              clr_ovr_s;
    logic [DATA_W-1:0] status_s;
    logic [DATA_W-1:0] rd_data_s;
    logic              unused_s;

    // Upper write-data bits carry no meaning for any register in the window.
    assign unused_s = &{1'b0, data[DATA_W-1:8]};

    // Address decode, FIFO flags and per-register access strobes.
    always_comb begin
        hit_s       = (addr[ADDR_W-1:2] == BASE[ADDR_W-1:2]);
        off_s       = addr[1:0];
        wr_hit_s    = write && hit_s;
        rd_hit_s    = read && hit_s;
        // Flags come from the pre-edge count so a same-cycle pop never makes
        // room for a push that arrives while full.
        tx_full_s   = (tx_count_r == CNT_FULL);
        tx_empty_s  = (tx_count_r == CNT_ZERO);
        push_req_s  = wr_hit_s && (off_s == OFF_TXDATA);
        push_s      = push_req_s && !tx_full_s;
        push_drop_s = push_req_s && tx_full_s;
        pop_s       = !tx_empty_s && tx_ready;
        rd_rx_s     = rd_hit_s && (off_s == OFF_RXDATA);
        stat_wr_s   = wr_hit_s && (off_s == OFF_STATUS);
        clr_ovf_s   = stat_wr_s && data[3];
        clr_ovr_s   = stat_wr_s && data[4];
    end

    // STATUS word assembled from live flags and sticky error bits.
    always_comb begin
        status_s              = DATA_ZERO;
        status_s[0]           = tx_full_s;
        status_s[1]           = tx_empty_s;
        status_s[2]           = rx_valid_r;
        status_s[3]           = tx_ovf_r;
        status_s[4]           = rx_ovr_r;
        status_s[8 +: CNT_W]  = tx_count_r;
    end

    // Read-data multiplexer over the four window registers.
    always_comb begin
        rd_data_s = DATA_ZERO;
        case (off_s)
            OFF_TXDATA: rd_data_s = DATA_ZERO;
            OFF_STATUS: rd_data_s = status_s;
            OFF_RXDATA: rd_data_s[7:0] = rx_hold_r;
            OFF_CYCLES: rd_data_s = cycles_r;
            default:    rd_data_s = DATA_ZERO;
        endcase
    end

    // ---------------------------------------------------------------- TX FIFO
    // FIFO storage; contents past the pointers are irrelevant, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            tx_mem_r[tx_wr_ptr_r] <= data[7:0];
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (power-of-2 depth).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wr_ptr_r <= PTR_ZERO;
            tx_rd_ptr_r <= PTR_ZERO;
            tx_count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                tx_wr_ptr_r <= tx_wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                tx_rd_ptr_r <= tx_rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   tx_count_r <= tx_count_r + CNT_ONE;
                2'b01:   tx_count_r <= tx_count_r - CNT_ONE;
                default: tx_count_r <= tx_count_r;
            endcase
        end
    end

    // Sticky TX overflow: set by a dropped push, cleared by W1C on bit 3.
    // Both events need a bus write, so they can never coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_ovf_r <= 1'b0;
        end else if (push_drop_s) begin
            tx_ovf_r <= 1'b1;
        end else if (clr_ovf_s) begin
            tx_ovf_r <= 1'b0;
        end
    end

    assign tx_data  = tx_mem_r[tx_rd_ptr_r];
    assign tx_valid = !tx_empty_s;

    // --------------------------------------------------------------------- RX
    // RX holding register: a strobe always wins over the clearing read, so a
    // strobe racing an RXDATA read leaves the new byte valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_hold_r  <= 8'h00;
            rx_valid_r <= 1'b0;
        end else if (rx_strobe) begin
            rx_hold_r  <= rx_byte;
            rx_valid_r <= 1'b1;
        end else if (rd_rx_s) begin
            rx_valid_r <= 1'b0;
        end
    end

    // Sticky RX overrun: an unread byte is overwritten. A strobe that races
    // the read of that byte is not an overrun. A new overrun beats a W1C.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_ovr_r <= 1'b0;
        end else if (rx_strobe && rx_valid_r && !rd_rx_s) begin
            rx_ovr_r <= 1'b1;
        end else if (clr_ovr_s) begin
            rx_ovr_r <= 1'b0;
        end
    end

    // ----------------------------------------------------------------- CYCLES
    // Free-running cycle counter, wraps at 2^DATA_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycles_r <= DATA_ZERO;
        end else begin
            cycles_r <= cycles_r + DATA_ONE;
        end
    end

    // --------------------------------------------------------------- read bus
    // Registered read data; zero whenever the previous cycle was no hit read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= DATA_ZERO;
        end else if (rd_hit_s) begin
            data_out <= rd_data_s;
        end else begin
            data_out <= DATA_ZERO;
        end
    end

`ifdef IO_SIM_PRINT_EN
    // Console echo of every byte accepted by the TX sink.
    always @(posedge clk) begin
        if (!rst && tx_valid && tx_ready) begin
            $write("%c", tx_data);
        end
    end
`endif

endmodule

// File: tb/tb_io_mmio_ctrl.sv
// Directed bench for io_mmio_ctrl: expected read data is queued when a bus
// cycle is driven and popped when data_out becomes visible one cycle later.
module tb_io_mmio_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic [15:0] data;
    logic        write;
    logic        read;
    logic [15:0] data_out;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_byte;
    logic        rx_strobe;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;
    logic [15:0] exp_q[$];

    io_mmio_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .data      (data),
        .write     (write),
        .read      (read),
        .data_out  (data_out),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_byte   (rx_byte),
        .rx_strobe (rx_strobe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus cycle, started at a negedge; the read result is checked at the
    // following negedge against the scoreboard.
    task automatic cyc(input logic w, input logic r, input logic [15:0] a,
                       input logic [15:0] d, input logic [15:0] exp, input string tag);
        write = w;
        read  = r;
        addr  = a;
        data  = d;
        exp_q.push_back(r ? exp : 16'h0000);
        @(posedge clk);
        #1;
        write     = 1'b0;
        read      = 1'b0;
        rx_strobe = 1'b0;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 16'h0001, 16'h0000);
        end else begin
            check(tag, data_out, exp_q.pop_front());
        end
    endtask

    initial begin
        rst = 1'b1; addr = 16'h0000; data = 16'h0000; write = 1'b0; read = 1'b0;
        tx_ready = 1'b0; rx_byte = 8'h00; rx_strobe = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_tx_valid", {15'd0, tx_valid}, 16'h0000);
        check("rst_data_out", data_out, 16'h0000);
        rst = 1'b0;

        // Status after reset.
        cyc(1'b0, 1'b1, 16'h0001, 16'h0000, 16'h0002, "status_reset");
        check("tx_valid_idle", {15'd0, tx_valid}, 16'h0000);

        // Three bytes in, then drained in order.
        cyc(1'b1, 1'b0, 16'h0000, 16'h0041, 16'h0000, "wr_A");
        cyc(1'b1, 1'b0, 16'h0000, 16'h0042, 16'h0000, "wr_B");
        cyc(1'b1, 1'b0, 16'h0000, 16'h0043, 16'h0000, "wr_C");
        cyc(1'b0, 1'b1, 16'h0001, 16'h0000, 16'h0300, "status_cnt3");
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("drain_abc_valid", {15'd0, tx_valid}, 16'h0001);
            check("drain_abc_data", {8'h00, tx_data}, 16'h0041 + 16'(i));
            cyc(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, "drain_abc_idle");
        end
        tx_ready = 1'b0;
        check("drained_valid", {15'd0, tx_valid}, 16'h0000);
        cyc(1'b0, 1'b1, 16'h0001, 16'h0000, 16'h0002, "status_cnt0");

        // Nine pushes into an 8-deep FIFO: last dropped, overflow flagged.
        for (int i = 0; i < 9; i++) begin
            cyc(1'b1, 1'b0, 16'h0000, 16'h0010 + 16'(i), 16'h0000, "fill");
        end
        cyc(1'b0, 1'b1, 16'h0001, 16'h0000, 16'h0809, "status_full_ovf");
        cyc(1'b1, 1'b0, 16'h0001, 16'h0008, 16'h0000, "w1c_ovf");
        cyc(1'b0, 1'b1, 16'h0001, 16'h0000, 16'h0801, "status_full");

        // Push while full with a simultaneous pop: push still dropped.
        check("head_full", {8'h00, tx_data}, 16'h0010);
        tx_ready = 1'b1;
        cyc(1'b1, 1'b0, 16'h0000, 16'h0099, 16'h0000, "push_pop_full");
        tx_ready = 1'b0;
        cyc(1'b0, 1'b1, 16'h0001, 16'h0000, 16'h0708, "status_cnt7_ovf");
        cyc(1'b1, 1'b0, 16'h0001, 16'h0008, 16'h0000, "w1c_ovf2");
        tx_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            check("drain_fill_data", {8'h00, tx_data}, 16'h0010 + 16'(i));
            cyc(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, "drain_fill_idle");
        end
        tx_ready = 1'b0;
        check("drain_fill_done", {15'd0, tx_valid}, 16'h0000);
        cyc(1'b0, 1'b1, 16'h0001, 16'h0000, 16'h0002, "status_after_fill");

        // Single RX byte.
        rx_byte = 8'h5A; rx_strobe = 1'b1;
        cyc(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, "rx_5a");
        cyc(1'b0, 1'b1, 16'h0002, 16'h0000, 16'h005A, "rxdata_5a");
        cyc(1'b0, 1'b1, 16'h0001, 16'h0000, 16'h0002, "status_rx_clr");

        // Overrun, then a strobe racing an RXDATA read.
        rx_byte = 8'h11; rx_strobe = 1'b1;
        cyc(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, "rx_11");
        rx_byte = 8'h22; rx_strobe = 1'b1;
        cyc(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, "rx_22");
        cyc(1'b0, 1'b1, 16'h0001, 16'h0000, 16'h0016, "status_rx_ovr");
        cyc(1'b1, 1'b0, 16'h0001, 16'h0010, 16'h0000, "w1c_ovr");
        cyc(1'b0, 1'b1, 16'h0001, 16'h0000, 16'h0006, "status_ovr_clr");
        rx_byte = 8'h33; rx_strobe = 1'b1;
        cyc(1'b0, 1'b1, 16'h0002, 16'h0000, 16'h0022, "rxdata_race");
        cyc(1'b0, 1'b1, 16'h0001, 16'h0000, 16'h0006, "status_race");
        cyc(1'b0, 1'b1, 16'h0002, 16'h0000, 16'h0033, "rxdata_33");
        cyc(1'b0, 1'b1, 16'h0001, 16'h0000, 16'h0002, "status_rx_done");

        // Accesses outside the window have no effect and read 0.
        cyc(1'b1, 1'b0, 16'h0004, 16'h005A, 16'h0000, "miss_wr");
        cyc(1'b1, 1'b0, 16'h0100, 16'h005A, 16'h0000, "miss_wr_hi");
        cyc(1'b0, 1'b1, 16'h0005, 16'h0000, 16'h0000, "miss_rd");
        check("miss_tx_valid", {15'd0, tx_valid}, 16'h0000);

        // Read and write together on TXDATA: read 0, push happens.
        cyc(1'b1, 1'b1, 16'h0000, 16'h0044, 16'h0000, "rdwr_txdata");
        cyc(1'b0, 1'b1, 16'h0001, 16'h0000, 16'h0100, "status_rdwr");
        check("rdwr_head", {8'h00, tx_data}, 16'h0044);
        tx_ready = 1'b1;
        cyc(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, "rdwr_drain");
        tx_ready = 1'b0;

        // Reset while the FIFO holds four bytes.
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 16'h0000, 16'h0001 + 16'(i), 16'h0000, "fill4");
        end
        check("fill4_valid", {15'd0, tx_valid}, 16'h0001);
        rst = 1'b1;
        #1;
        check("midrst_valid", {15'd0, tx_valid}, 16'h0000);
        check("midrst_data_out", data_out, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, "post_rst_idle");
        cyc(1'b0, 1'b1, 16'h0003, 16'h0000, 16'h0001, "cycles_first");
        cyc(1'b0, 1'b1, 16'h0003, 16'h0000, 16'h0002, "cycles_second");
        cyc(1'b1, 1'b0, 16'h0003, 16'hFFFF, 16'h0000, "cycles_wr");
        cyc(1'b0, 1'b1, 16'h0003, 16'h0000, 16'h0004, "cycles_after_wr");
        cyc(1'b0, 1'b1, 16'h0001, 16'h0000, 16'h0002, "status_post_rst");
        cyc(1'b0, 1'b1, 16'h0002, 16'h0000, 16'h0000, "rxdata_post_rst");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
